// File: rtl/trx_pkg.sv
// Shared packet layout helpers for the queued transceiver.
// QUEUED_TRANSCEIVER_BROADCAST_EN turns the all-ones destination id into broadcast.
package trx_pkg;

`ifdef QUEUED_TRANSCEIVER_BROADCAST_EN
  localparam bit BCAST_ALL_ONES = 1'b1;
`else
  localparam bit BCAST_ALL_ONES = 1'b0;
`endif

  // Packet is {dest_id, data, src_id} with src_id in the least significant bits.
  function automatic int pkt_width(input int id_w, input int data_w);
    return 2 * id_w + data_w;
  endfunction

  function automatic int src_lsb();
    return 0;
  endfunction

  function automatic int data_lsb(input int id_w);
    return id_w;
  endfunction

  function automatic int dest_lsb(input int id_w, input int data_w);
    return id_w + data_w;
  endfunction

endpackage

// File: rtl/trx_fifo.sv
// Circular FIFO with pointer wrap, occupancy count and a zeroed head when empty.
module trx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign valid   = (count != '0);
  // Full is judged on the current count, so a same-cycle pop does not make room.
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;
  assign rdata   = valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/queued_transceiver.sv
// Node transceiver: queued TX towards the link, per-source RX mailboxes with overrun flag.
// Broadcast reception is enabled by defining QUEUED_TRANSCEIVER_BROADCAST_EN.
import trx_pkg::*;

module queued_transceiver #(
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 32,
  parameter int TXQ_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ID_WIDTH-1:0]            id,
  input  logic [ID_WIDTH-1:0]            tx_dest_id,
  input  logic [DATA_WIDTH-1:0]          tx_data,
  input  logic                           tx_enable,
  output logic                           tx_full,
  output logic [2*ID_WIDTH+DATA_WIDTH-1:0] tx_out,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  input  logic [2*ID_WIDTH+DATA_WIDTH-1:0] rx_in,
  input  logic                           rx_valid,
  input  logic                           rtr_write_enable,
  input  logic [ID_WIDTH-1:0]            rx_addr,
  input  logic                           rx_read,
  output logic [WIDTH-1:0]               flag_res,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           rx_overrun
);

  localparam int NUM_NODES = 2 ** ID_WIDTH;
  localparam int PKT_W     = pkt_width(ID_WIDTH, DATA_WIDTH);
  localparam int SRC_LSB   = src_lsb();
  localparam int DATA_LSB  = data_lsb(ID_WIDTH);
  localparam int DEST_LSB  = dest_lsb(ID_WIDTH, DATA_WIDTH);

  trx_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_enable),
    .wdata ({tx_dest_id, tx_data, id}),
    .pop   (tx_ready),
    .rdata (tx_out),
    .valid (tx_valid),
    .full  (tx_full)
  );

  logic [ID_WIDTH-1:0]   rx_dest;
  logic [ID_WIDTH-1:0]   rx_src;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  is_bcast;
  logic                  accept;
  logic                  read_same;
  logic [NUM_NODES-1:0]  flag;
  logic [DATA_WIDTH-1:0] mbox [NUM_NODES];

  assign rx_dest   = rx_in[DEST_LSB +: ID_WIDTH];
  assign rx_data   = rx_in[DATA_LSB +: DATA_WIDTH];
  assign rx_src    = rx_in[SRC_LSB  +: ID_WIDTH];
  // A broadcast is never echoed back into the sender's own mailbox.
  assign is_bcast  = BCAST_ALL_ONES && (rx_dest == '1);
  assign accept    = rx_valid && rtr_write_enable &&
                     (is_bcast ? (rx_src != id) : (rx_dest == id));
  assign read_same = rx_read && (rx_addr == rx_src);

  always_ff @(posedge clk) begin
    if (rst) begin
      flag       <= '0;
      rx_overrun <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) mbox[i] <= '0;
    end else begin
      if (rx_read) flag[rx_addr] <= 1'b0;
      // Arrival is applied after the read clear so a same-slot write wins.
      if (accept) begin
        mbox[rx_src] <= rx_data;
        flag[rx_src] <= 1'b1;
        if (flag[rx_src] && !read_same) rx_overrun <= 1'b1;
      end
    end
  end

  assign flag_res = WIDTH'(flag[rx_addr]);
  assign data_out = mbox[rx_addr];

endmodule

// File: tb/tb_queued_transceiver.sv
// Randomized and directed bench for queued_transceiver against a queue/array reference model.
module tb_queued_transceiver;

  localparam int IDW   = 2;
  localparam int DW    = 32;
  localparam int RW    = 32;
  localparam int DEPTH = 4;
  localparam int PW    = 2 * IDW + DW;
  localparam int NN    = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [IDW-1:0] id;
  logic [IDW-1:0] tx_dest_id;
  logic [DW-1:0]  tx_data;
  logic           tx_enable;
  logic           tx_full;
  logic [PW-1:0]  tx_out;
  logic           tx_valid;
  logic           tx_ready;
  logic [PW-1:0]  rx_in;
  logic           rx_valid;
  logic           rtr_write_enable;
  logic [IDW-1:0] rx_addr;
  logic           rx_read;
  logic [RW-1:0]  flag_res;
  logic [DW-1:0]  data_out;
  logic           rx_overrun;

  queued_transceiver #(
    .ID_WIDTH   (IDW),
    .DATA_WIDTH (DW),
    .WIDTH      (RW),
    .TXQ_DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id               (id),
    .tx_dest_id       (tx_dest_id),
    .tx_data          (tx_data),
    .tx_enable        (tx_enable),
    .tx_full          (tx_full),
    .tx_out           (tx_out),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_in            (rx_in),
    .rx_valid         (rx_valid),
    .rtr_write_enable (rtr_write_enable),
    .rx_addr          (rx_addr),
    .rx_read          (rx_read),
    .flag_res         (flag_res),
    .data_out         (data_out),
    .rx_overrun       (rx_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [PW-1:0] q[$];
  logic [DW-1:0] m_mbox [NN];
  logic          m_flag [NN];
  logic          m_ovr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pkt(input int dest, input logic [DW-1:0] d, input int src);
    return {IDW'(dest), d, IDW'(src)};
  endfunction

  task automatic model_clear();
    q.delete();
    m_ovr = 1'b0;
    for (int i = 0; i < NN; i++) begin
      m_mbox[i] = '0;
      m_flag[i] = 1'b0;
    end
  endtask

  // Applies the edge behaviour described by the transceiver rules to the model.
  task automatic model_edge();
    int dest, src;
    bit acc, prior, was_full, do_pop;
    if (rst) begin
      model_clear();
      return;
    end
    was_full = (q.size() == DEPTH);
    do_pop   = (q.size() != 0) && tx_ready;
    if (do_pop) void'(q.pop_front());
    if (tx_enable && !was_full) q.push_back({tx_dest_id, tx_data, id});

    dest = int'(rx_in[PW-1 -: IDW]);
    src  = int'(rx_in[IDW-1:0]);
`ifdef QUEUED_TRANSCEIVER_BROADCAST_EN
    if (dest == NN - 1) acc = rx_valid && rtr_write_enable && (src != int'(id));
    else                acc = rx_valid && rtr_write_enable && (dest == int'(id));
`else
    acc = rx_valid && rtr_write_enable && (dest == int'(id));
`endif
    prior = m_flag[src];
    if (rx_read) m_flag[rx_addr] = 1'b0;
    if (acc) begin
      if (prior && !(rx_read && int'(rx_addr) == src)) m_ovr = 1'b1;
      m_mbox[src] = rx_in[IDW +: DW];
      m_flag[src] = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".tx_valid"}, 64'(tx_valid), 64'(q.size() != 0));
    check({tag, ".tx_full"}, 64'(tx_full), 64'(q.size() == DEPTH));
    check({tag, ".tx_out"}, 64'(tx_out), 64'((q.size() != 0) ? q[0] : '0));
    check({tag, ".flag_res"}, 64'(flag_res), 64'(m_flag[rx_addr]));
    check({tag, ".data_out"}, 64'(data_out), 64'(m_mbox[rx_addr]));
    check({tag, ".overrun"}, 64'(rx_overrun), 64'(m_ovr));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic scan_slots(input string tag);
    logic [IDW-1:0] save;
    save = rx_addr;
    for (int i = 0; i < NN; i++) begin
      rx_addr = IDW'(i);
      #1;
      check({tag, ".scan_flag"}, 64'(flag_res), 64'(m_flag[i]));
      check({tag, ".scan_data"}, 64'(data_out), 64'(m_mbox[i]));
    end
    rx_addr = save;
  endtask

  task automatic idle_inputs();
    tx_enable = 0; tx_ready = 0; rx_valid = 0; rx_read = 0;
    rtr_write_enable = 1; rx_in = '0; tx_dest_id = '0; tx_data = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    step("reset");
    step("reset");
    rst = 0;
  endtask

  initial begin
    logic [PW-1:0] held;
    rst = 1; id = 2'd1; rx_addr = '0;
    idle_inputs();
    model_clear();

    // Reset and idle
    do_reset();
    step("idle");
    scan_slots("idle");

    // Single push held under backpressure, then accepted
    id = 2'd1; tx_enable = 1; tx_dest_id = 2'd2; tx_data = 32'hA5;
    step("push_a5");
    tx_enable = 0;
    check("tx_out_a5", 64'(tx_out), 64'(pkt(2, 32'hA5, 1)));
    held = tx_out;
    for (int i = 0; i < 3; i++) begin
      step("hold");
      check("tx_hold", 64'(tx_out), 64'(held));
    end
    tx_ready = 1;
    step("pop_a5");
    check("tx_valid_after_pop", 64'(tx_valid), 64'(0));

    // Fill beyond depth, drain in order, then wrap
    tx_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      tx_enable = 1; tx_data = DW'(i); tx_dest_id = 2'd3;
      step("fill");
      if (i == 4) check("full_at_4", 64'(tx_full), 64'(1));
    end
    tx_enable = 0; tx_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", 64'(tx_out[IDW +: DW]), 64'(i));
      step("drain");
    end
    check("empty_after_drain", 64'(tx_valid), 64'(0));
    for (int i = 0; i < 6; i++) begin
      tx_enable = 1; tx_data = DW'(32'h100 + i);
      step("wrap");
      check("wrap_head", 64'(tx_out[IDW +: DW]), 64'(32'h100 + i));
    end
    tx_enable = 0;
    step("wrap_end");

    // RX mailbox: accept, gated, misaddressed, overrun
    do_reset();
    id = 2'd2; rx_addr = 2'd3;
    rx_valid = 1; rx_in = pkt(2, 32'h1234, 3);
    step("rx_accept");
    check("rx_flag3", 64'(flag_res), 64'(1));
    check("rx_data3", 64'(data_out), 64'(32'h1234));
    rtr_write_enable = 0; rx_in = pkt(2, 32'h5555, 3);
    step("rx_gated");
    rtr_write_enable = 1; rx_in = pkt(1, 32'h6666, 3);
    step("rx_wrong_dest");
    check("rx_data_kept", 64'(data_out), 64'(32'h1234));
    rx_in = pkt(2, 32'hBEEF, 3);
    step("rx_overwrite");
    check("rx_overrun_set", 64'(rx_overrun), 64'(1));
    check("rx_new_data", 64'(data_out), 64'(32'hBEEF));
    rx_valid = 0; rx_read = 1;
    step("rx_consume");
    check("rx_flag_cleared", 64'(flag_res), 64'(0));
    rx_read = 0;

    do_reset();
    id = 2'd2; rx_addr = 2'd3; rx_valid = 1;
    rx_in = pkt(2, 32'h1111, 3);
    step("rx_first");
    rx_read = 1; rx_in = pkt(2, 32'h2222, 3);
    step("rx_write_wins");
    check("ww_flag", 64'(flag_res), 64'(1));
    check("ww_data", 64'(data_out), 64'(32'h2222));
    check("ww_no_ovr", 64'(rx_overrun), 64'(0));
    rx_read = 1; rx_addr = 2'd0; rx_in = pkt(2, 32'h3333, 1);
    step("rx_indep");
    rx_read = 0; rx_valid = 0;
    scan_slots("indep");

    // Broadcast destination (all ones)
    do_reset();
    id = 2'd0; rx_valid = 1; rx_addr = 2'd1;
    rx_in = pkt(3, 32'hCAFE, 1);
    step("bcast");
`ifdef QUEUED_TRANSCEIVER_BROADCAST_EN
    check("bcast_flag1", 64'(flag_res), 64'(1));
`else
    check("bcast_flag1", 64'(flag_res), 64'(0));
`endif
    rx_in = pkt(3, 32'hD00D, 0); rx_addr = 2'd0;
    step("bcast_self");
    check("bcast_self_flag", 64'(flag_res), 64'(0));
    id = 2'd3; rx_in = pkt(3, 32'hF00D, 2); rx_addr = 2'd2;
    step("id3_accept");
    check("id3_flag", 64'(flag_res), 64'(1));
    rx_valid = 0;

    // Randomized traffic
    do_reset();
    id = IDW'($urandom_range(0, NN - 1));
    for (int n = 0; n < 400; n++) begin
      rst              = ($urandom_range(0, 99) == 0);
      tx_enable        = $urandom_range(0, 1);
      tx_ready         = ($urandom_range(0, 2) == 0);
      tx_dest_id       = IDW'($urandom);
      tx_data          = $urandom;
      rx_valid         = $urandom_range(0, 1);
      rtr_write_enable = ($urandom_range(0, 4) != 0);
      rx_in            = {($urandom_range(0, 1) ? id : IDW'($urandom)), DW'($urandom), IDW'($urandom)};
      rx_addr          = IDW'($urandom);
      rx_read          = ($urandom_range(0, 3) == 0);
      step("rand");
    end
    rst = 0; idle_inputs();
    step("final");
    scan_slots("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
